alu_exec_unit: RTL and testbench

//  Decode-and-execute ALU stage for the RV32I core: takes ALUOp/Funct3/Funct7 plus operands and returns a registered result.

---
 rtl/alu_exec_pkg.sv | 62 ++++++
 rtl/alu_exec_if.sv | 36 +++
 rtl/alu_muldiv_seq.sv | 153 +++++++++++++++
 rtl/alu_exec_unit.sv | 269 ++++++++++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_exec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_pkg
// Description : Shared types and constants for the RV32I ALU execute stage:
//               ALUOp / funct7 encodings, the decoded operation enum and the
//               execute-stage FSM state enum.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_exec_pkg;

    // ALUOp field as produced by the main decoder
    localparam logic [1:0] ALUOP_MEM    = 2'b00;  // LW/SW/AUIPC address add
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

    // funct7 encodings of interest
    localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;  // SUB / SRA
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;  // RV32M

    typedef enum logic [4:0] {
        OP_ADD    = 5'd0,
        OP_SUB    = 5'd1,
        OP_SLL    = 5'd2,
        OP_SLT    = 5'd3,
        OP_SLTU   = 5'd4,
        OP_XOR    = 5'd5,
        OP_SRL    = 5'd6,
        OP_SRA    = 5'd7,
        OP_OR     = 5'd8,
        OP_AND    = 5'd9,
        OP_BEQ    = 5'd10,
        OP_BNE    = 5'd11,
        OP_BLT    = 5'd12,
        OP_BGE    = 5'd13,
        OP_BLTU   = 5'd14,
        OP_BGEU   = 5'd15,
        OP_MUL    = 5'd16,
        OP_MULH   = 5'd17,
        OP_MULHSU = 5'd18,
        OP_MULHU  = 5'd19,
        OP_DIV    = 5'd20,
        OP_DIVU   = 5'd21,
        OP_REM    = 5'd22,
        OP_REMU   = 5'd23
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_e;

    // True for the four division-family operations
    function automatic logic is_div_op(input alu_op_e op);
        return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_exec_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_if
// Description : Request/response bundle of the ALU execute stage.
//               Request : in_valid/in_ready, alu_op, funct7, funct3, src_a, src_b
//               Response: out_valid/out_ready, result, branch_taken, illegal
//               master = issuing/consuming side, slave = execute unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_exec_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [1:0]            alu_op;
    logic [6:0]            funct7;
    logic [2:0]            funct3;
    logic [DATA_WIDTH-1:0] src_a;
    logic [DATA_WIDTH-1:0] src_b;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] result;
    logic                  branch_taken;
    logic                  illegal;

    modport master (
        output in_valid, alu_op, funct7, funct3, src_a, src_b, out_ready,
        input  in_ready, out_valid, result, branch_taken, illegal
    );

    modport slave (
        input  in_valid, alu_op, funct7, funct3, src_a, src_b, out_ready,
        output in_ready, out_valid, result, branch_taken, illegal
    );
endinterface
`default_nettype wire

// File: rtl/alu_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_muldiv_seq
// Description : Iterative RV32M engine. Shift-add multiply and restoring
//               divide on operand magnitudes, sign applied on the way out.
//               Runs DATA_WIDTH steps after a start pulse.
//               Compiled only when ALU_MULDIV_EN is defined.
// Ports       : clk, reset        - clock, synchronous active-high reset
//               start_i, op_i     - launch pulse and operation
//               a_i, b_i          - operands captured on start_i
//               busy_o            - iteration in progress
//               done_o            - current cycle performs the final step;
//                                   result_o is valid from the next cycle
//               result_o          - selected product/quotient/remainder
// Revision    : 1.0 - initial release
// ============================================================================
`ifdef ALU_MULDIV_EN
module alu_muldiv_seq
    import alu_exec_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    input  wire logic                  start_i,
    input  wire alu_op_e               op_i,
    input  wire logic [DATA_WIDTH-1:0] a_i,
    input  wire logic [DATA_WIDTH-1:0] b_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic [DATA_WIDTH-1:0]      result_o
);
    localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
    localparam logic [CNT_W-1:0] c_last_step = CNT_W'(DATA_WIDTH - 1);

    // acc holds {hi, lo}: product for multiply, {remainder, quotient} for divide
    logic [2*DATA_WIDTH-1:0] acc_q, acc_d;
    logic [DATA_WIDTH-1:0]   opnd_q, opnd_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    busy_q, busy_d;
    logic                    is_div_q, is_div_d;
    logic                    hi_q, hi_d;        // MULH* upper half, or REM*
    logic                    neg_q, neg_d;      // negate product / quotient
    logic                    neg_rem_q, neg_rem_d;

    logic                    w_a_signed, w_b_signed, w_a_neg, w_b_neg;
    logic [DATA_WIDTH-1:0]   w_mag_a, w_mag_b;
    logic [DATA_WIDTH:0]     w_mul_sum, w_div_shift, w_div_diff;
    logic                    w_last;

    assign w_last = busy_q && (cnt_q == c_last_step);

    always_comb begin
        w_a_signed = 1'b0;
        w_b_signed = 1'b0;
        is_div_d   = 1'b0;
        hi_d       = 1'b0;
        case (op_i)
            OP_MULH:   begin w_a_signed = 1'b1; w_b_signed = 1'b1; hi_d = 1'b1; end
            OP_MULHSU: begin w_a_signed = 1'b1; hi_d = 1'b1; end
            OP_MULHU:  hi_d = 1'b1;
            OP_DIV:    begin w_a_signed = 1'b1; w_b_signed = 1'b1; is_div_d = 1'b1; end
            OP_DIVU:   is_div_d = 1'b1;
            OP_REM:    begin w_a_signed = 1'b1; w_b_signed = 1'b1; is_div_d = 1'b1; hi_d = 1'b1; end
            OP_REMU:   begin is_div_d = 1'b1; hi_d = 1'b1; end
            default:   ;
        endcase
        w_a_neg   = w_a_signed && a_i[DATA_WIDTH-1];
        w_b_neg   = w_b_signed && b_i[DATA_WIDTH-1];
        w_mag_a   = w_a_neg ? -a_i : a_i;
        w_mag_b   = w_b_neg ? -b_i : b_i;
        neg_d     = w_a_neg ^ w_b_neg;
        // remainder takes the sign of the dividend
        neg_rem_d = w_a_neg;
    end

    // One iteration of each algorithm
    always_comb begin
        w_mul_sum   = {1'b0, acc_q[2*DATA_WIDTH-1:DATA_WIDTH]}
                    + (acc_q[0] ? {1'b0, opnd_q} : '0);
        w_div_shift = {acc_q[2*DATA_WIDTH-1:DATA_WIDTH], acc_q[DATA_WIDTH-1]};
        w_div_diff  = w_div_shift - {1'b0, opnd_q};
    end

    always_comb begin
        acc_d  = acc_q;
        opnd_d = opnd_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (start_i) begin
            acc_d  = {{DATA_WIDTH{1'b0}}, w_mag_a};
            opnd_d = w_mag_b;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (is_div_q) begin
                if (!w_div_diff[DATA_WIDTH])
                    acc_d = {w_div_diff[DATA_WIDTH-1:0], acc_q[DATA_WIDTH-2:0], 1'b1};
                else
                    acc_d = {w_div_shift[DATA_WIDTH-1:0], acc_q[DATA_WIDTH-2:0], 1'b0};
            end else begin
                acc_d = {w_mul_sum, acc_q[DATA_WIDTH-1:1]};
            end
            cnt_d = cnt_q + 1'b1;
            if (w_last)
                busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q     <= '0;
            opnd_q    <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            is_div_q  <= 1'b0;
            hi_q      <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            opnd_q <= opnd_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            if (start_i) begin
                is_div_q  <= is_div_d;
                hi_q      <= hi_d;
                neg_q     <= neg_d;
                neg_rem_q <= neg_rem_d;
            end
        end
    end

    logic [2*DATA_WIDTH-1:0] w_prod;
    logic [DATA_WIDTH-1:0]   w_quo, w_rem;

    always_comb begin
        w_prod = neg_q ? -acc_q : acc_q;
        w_quo  = neg_q ? -acc_q[DATA_WIDTH-1:0] : acc_q[DATA_WIDTH-1:0];
        w_rem  = neg_rem_q ? -acc_q[2*DATA_WIDTH-1:DATA_WIDTH]
                           : acc_q[2*DATA_WIDTH-1:DATA_WIDTH];
        if (is_div_q)
            result_o = hi_q ? w_rem : w_quo;
        else
            result_o = hi_q ? w_prod[2*DATA_WIDTH-1:DATA_WIDTH] : w_prod[DATA_WIDTH-1:0];
    end

    assign busy_o = busy_q;
    assign done_o = w_last;

endmodule
`endif
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_unit
// Description : RV32I decode-and-execute ALU stage with valid/ready handshake
//               and registered result, branch_taken and illegal flags.
//               Single-cycle ops answer one cycle after accept; RV32M
//               multiply/divide (ALU_MULDIV_EN defined) take DATA_WIDTH+1
//               cycles except the divide-by-zero and signed-overflow cases.
// Ports       : clk    - core clock
//               reset  - synchronous active-high reset
//               bus    - alu_exec_if slave (request and response channels)
// Config      : ALU_MULDIV_EN - enables RV32M; otherwise funct7=0000001 is
//               reported illegal.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_exec_unit
    import alu_exec_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input wire logic   clk,
    input wire logic   reset,
    alu_exec_if.slave  bus
);
    localparam int SHAMT_W = $clog2(DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0] c_signed_min = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] c_all_ones   = {DATA_WIDTH{1'b1}};

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  taken_q, taken_d;
    logic                  illegal_q, illegal_d;

    alu_op_e               w_op;
    logic                  w_dec_illegal;
    logic                  w_multi;
    logic                  w_ready, w_accept, w_start, w_out_valid;
    logic                  w_seq_busy, w_seq_done;
    logic [SHAMT_W-1:0]    w_shamt;
    logic [DATA_WIDTH-1:0] w_a, w_b;

    assign w_a     = bus.src_a;
    assign w_b     = bus.src_b;
    assign w_shamt = bus.src_b[SHAMT_W-1:0];

    // ------------------------------------------------------------------
    // Decode ALUOp/funct3/funct7 into a single operation code
    // ------------------------------------------------------------------
    always_comb begin
        w_op          = OP_ADD;
        w_dec_illegal = 1'b0;
        case (bus.alu_op)
            ALUOP_MEM: w_op = OP_ADD;
            ALUOP_BRANCH: begin
                case (bus.funct3)
                    3'b000:  w_op = OP_BEQ;
                    3'b001:  w_op = OP_BNE;
                    3'b100:  w_op = OP_BLT;
                    3'b101:  w_op = OP_BGE;
                    3'b110:  w_op = OP_BLTU;
                    3'b111:  w_op = OP_BGEU;
                    default: w_dec_illegal = 1'b1;
                endcase
            end
            ALUOP_RTYPE: begin
                if (bus.funct7 == FUNCT7_BASE) begin
                    case (bus.funct3)
                        3'b000:  w_op = OP_ADD;
                        3'b001:  w_op = OP_SLL;
                        3'b010:  w_op = OP_SLT;
                        3'b011:  w_op = OP_SLTU;
                        3'b100:  w_op = OP_XOR;
                        3'b101:  w_op = OP_SRL;
                        3'b110:  w_op = OP_OR;
                        default: w_op = OP_AND;
                    endcase
                end else if (bus.funct7 == FUNCT7_ALT) begin
                    case (bus.funct3)
                        3'b000:  w_op = OP_SUB;
                        3'b101:  w_op = OP_SRA;
                        default: w_dec_illegal = 1'b1;
                    endcase
                end else if (bus.funct7 == FUNCT7_MULDIV) begin
`ifdef ALU_MULDIV_EN
                    case (bus.funct3)
                        3'b000:  w_op = OP_MUL;
                        3'b001:  w_op = OP_MULH;
                        3'b010:  w_op = OP_MULHSU;
                        3'b011:  w_op = OP_MULHU;
                        3'b100:  w_op = OP_DIV;
                        3'b101:  w_op = OP_DIVU;
                        3'b110:  w_op = OP_REM;
                        default: w_op = OP_REMU;
                    endcase
`else
                    w_dec_illegal = 1'b1;
`endif
                end else begin
                    w_dec_illegal = 1'b1;
                end
            end
            default: begin  // I-type: funct7 only qualifies the shifts
                case (bus.funct3)
                    3'b000: w_op = OP_ADD;
                    3'b001: begin
                        if (bus.funct7 == FUNCT7_BASE) w_op = OP_SLL;
                        else                           w_dec_illegal = 1'b1;
                    end
                    3'b010: w_op = OP_SLT;
                    3'b011: w_op = OP_SLTU;
                    3'b100: w_op = OP_XOR;
                    3'b101: begin
                        if (bus.funct7 == FUNCT7_BASE)     w_op = OP_SRL;
                        else if (bus.funct7 == FUNCT7_ALT) w_op = OP_SRA;
                        else                               w_dec_illegal = 1'b1;
                    end
                    3'b110:  w_op = OP_OR;
                    default: w_op = OP_AND;
                endcase
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Single-cycle datapath; w_multi flags ops handed to the sequencer
    // ------------------------------------------------------------------
    always_comb begin
        result_d  = '0;
        taken_d   = 1'b0;
        illegal_d = w_dec_illegal;
        w_multi   = 1'b0;
        if (!w_dec_illegal) begin
            case (w_op)
                OP_ADD:  result_d = w_a + w_b;
                OP_SUB:  result_d = w_a - w_b;
                OP_SLL:  result_d = w_a << w_shamt;
                OP_SLT:  result_d = {{(DATA_WIDTH-1){1'b0}}, $signed(w_a) < $signed(w_b)};
                OP_SLTU: result_d = {{(DATA_WIDTH-1){1'b0}}, w_a < w_b};
                OP_XOR:  result_d = w_a ^ w_b;
                OP_SRL:  result_d = w_a >> w_shamt;
                OP_SRA:  result_d = $signed(w_a) >>> w_shamt;
                OP_OR:   result_d = w_a | w_b;
                OP_AND:  result_d = w_a & w_b;
                OP_BEQ:  taken_d  = (w_a == w_b);
                OP_BNE:  taken_d  = (w_a != w_b);
                OP_BLT:  taken_d  = ($signed(w_a) <  $signed(w_b));
                OP_BGE:  taken_d  = ($signed(w_a) >= $signed(w_b));
                OP_BLTU: taken_d  = (w_a <  w_b);
                OP_BGEU: taken_d  = (w_a >= w_b);
`ifdef ALU_MULDIV_EN
                // Divide-by-zero and MIN/-1 are resolved here in one cycle
                OP_DIV: begin
                    if (w_b == '0)
                        result_d = c_all_ones;
                    else if (w_a == c_signed_min && w_b == c_all_ones)
                        result_d = c_signed_min;
                    else
                        w_multi = 1'b1;
                end
                OP_DIVU: begin
                    if (w_b == '0) result_d = c_all_ones;
                    else           w_multi  = 1'b1;
                end
                OP_REM: begin
                    if (w_b == '0)
                        result_d = w_a;
                    else if (w_a == c_signed_min && w_b == c_all_ones)
                        result_d = '0;
                    else
                        w_multi = 1'b1;
                end
                OP_REMU: begin
                    if (w_b == '0) result_d = w_a;
                    else           w_multi  = 1'b1;
                end
                OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU: w_multi = 1'b1;
`endif
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (w_accept) begin
                    if (!w_multi)             state_d = DONE;
                    else if (is_div_op(w_op)) state_d = DIV;
                    else                      state_d = MUL;
                end
            end
            MUL, DIV: if (w_seq_done)    state_d = DONE;
            DONE:     if (bus.out_ready) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // FSM: outputs. in_ready is masked by reset so it reads 0 in the
    // reset cycle regardless of the state register.
    always_comb begin
        w_ready     = (state_q == IDLE) && !reset && !w_seq_busy;
        w_accept    = bus.in_valid && w_ready;
        w_start     = w_accept && w_multi;
        w_out_valid = (state_q == DONE);
    end

    // ------------------------------------------------------------------
    // Result and flag registers, loaded on accept only so they hold
    // steady while the consumer stalls
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            result_q  <= '0;
            taken_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else if (w_accept) begin
            result_q  <= result_d;
            taken_q   <= taken_d;
            illegal_q <= illegal_d;
        end
    end

`ifdef ALU_MULDIV_EN
    logic                  seq_sel_q;  // response comes from the sequencer
    logic [DATA_WIDTH-1:0] w_seq_result;

    always_ff @(posedge clk) begin
        if (reset)         seq_sel_q <= 1'b0;
        else if (w_accept) seq_sel_q <= w_multi;
    end

    alu_muldiv_seq #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_muldiv (
        .clk      (clk),
        .reset    (reset),
        .start_i  (w_start),
        .op_i     (w_op),
        .a_i      (w_a),
        .b_i      (w_b),
        .busy_o   (w_seq_busy),
        .done_o   (w_seq_done),
        .result_o (w_seq_result)
    );

    assign bus.result = seq_sel_q ? w_seq_result : result_q;
`else
    assign w_seq_busy = 1'b0;
    assign w_seq_done = 1'b0;
    assign bus.result = result_q;
`endif

    assign bus.in_ready     = w_ready;
    assign bus.out_valid    = w_out_valid;
    assign bus.branch_taken = taken_q;
    assign bus.illegal      = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_exec_unit
// Description : Self-checking bench for alu_exec_unit: directed vector table
//               plus hand-written backpressure and reset-abort sequences.
//               RV32M vectors are included when ALU_MULDIV_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_exec_unit;
    import alu_exec_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    alu_exec_if #(.DATA_WIDTH(32)) bus_if ();

    alu_exec_unit #(.DATA_WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        taken;
        logic        ill;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string name, input logic [1:0] op, input logic [6:0] f7,
                                input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] res, input logic taken, input logic ill,
                                input int lat);
        vec_t v;
        v.name = name; v.op = op; v.f7 = f7; v.f3 = f3; v.a = a; v.b = b;
        v.res = res; v.taken = taken; v.ill = ill; v.lat = lat;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (bus_if.in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("in_ready_timeout", {31'b0, bus_if.in_ready}, 32'd1);
    endtask

    // Present one request; returns at the negedge after the accepting edge
    task automatic issue(input vec_t v);
        wait_ready();
        bus_if.alu_op   = v.op;
        bus_if.funct7   = v.f7;
        bus_if.funct3   = v.f3;
        bus_if.src_a    = v.a;
        bus_if.src_b    = v.b;
        bus_if.in_valid = 1'b1;
        @(negedge clk);
        bus_if.in_valid = 1'b0;
    endtask

    // Latency 1 = out_valid seen at the first negedge after the accept edge
    task automatic wait_valid(output int lat);
        lat = 1;
        while (bus_if.out_valid !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic consume();
        bus_if.out_ready = 1'b1;
        @(negedge clk);
        bus_if.out_ready = 1'b0;
    endtask

    initial begin
        int   lat;
        int   seen;
        vec_t v;

        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b0;
        bus_if.alu_op    = '0;
        bus_if.funct7    = '0;
        bus_if.funct3    = '0;
        bus_if.src_a     = '0;
        bus_if.src_b     = '0;

        //                name          op     f7          f3      a             b             result        tk   ill  lat
        vecs.push_back(mk("sub_wrap",   2'b10, 7'b0100000, 3'b000, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 1));
        vecs.push_back(mk("add_wrap",   2'b10, 7'b0000000, 3'b000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0, 1));
        vecs.push_back(mk("srai",       2'b11, 7'b0100000, 3'b101, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1'b0, 1'b0, 1));
        vecs.push_back(mk("srai_badf7", 2'b11, 7'b0000001, 3'b101, 32'h8000_0000, 32'h0000_0024, 32'h0000_0000, 1'b0, 1'b1, 1));
        vecs.push_back(mk("blt",        2'b01, 7'b0000000, 3'b100, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1));
        vecs.push_back(mk("bltu",       2'b01, 7'b0000000, 3'b110, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0, 1));
        vecs.push_back(mk("br_f3_010",  2'b01, 7'b0000000, 3'b010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1, 1));
        vecs.push_back(mk("beq",        2'b01, 7'b0000000, 3'b000, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b1, 1'b0, 1));
        vecs.push_back(mk("bne_eq",     2'b01, 7'b0000000, 3'b001, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b0, 1'b0, 1));
        vecs.push_back(mk("bge",        2'b01, 7'b0000000, 3'b101, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0, 1));
        vecs.push_back(mk("bgeu",       2'b01, 7'b0000000, 3'b111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1));
        vecs.push_back(mk("mem_add",    2'b00, 7'b1111111, 3'b111, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0, 1'b0, 1));
        vecs.push_back(mk("sll",        2'b10, 7'b0000000, 3'b001, 32'h0000_0001, 32'h0000_003F, 32'h8000_0000, 1'b0, 1'b0, 1));
        vecs.push_back(mk("slt",        2'b10, 7'b0000000, 3'b010, 32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1));
        vecs.push_back(mk("sltu",       2'b10, 7'b0000000, 3'b011, 32'h8000_0000, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0, 1));
        vecs.push_back(mk("xor",        2'b10, 7'b0000000, 3'b100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 1'b0, 1));
        vecs.push_back(mk("srl",        2'b10, 7'b0000000, 3'b101, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 1'b0, 1'b0, 1));
        vecs.push_back(mk("or",         2'b10, 7'b0000000, 3'b110, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0, 1'b0, 1));
        vecs.push_back(mk("and",        2'b10, 7'b0000000, 3'b111, 32'hA5A5_A5A5, 32'h0F0F_0F0F, 32'h0505_0505, 1'b0, 1'b0, 1));
        vecs.push_back(mk("r_alt_f3",   2'b10, 7'b0100000, 3'b001, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1, 1));
        vecs.push_back(mk("r_bad_f7",   2'b10, 7'b0000010, 3'b000, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1, 1));
        vecs.push_back(mk("slli_badf7", 2'b11, 7'b0100000, 3'b001, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1, 1));
        vecs.push_back(mk("sltiu",      2'b11, 7'b0110011, 3'b011, 32'h0000_0005, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1));
`ifdef ALU_MULDIV_EN
        vecs.push_back(mk("div_neg",    2'b10, 7'b0000001, 3'b100, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 1'b0, 33));
        vecs.push_back(mk("div_zero",   2'b10, 7'b0000001, 3'b100, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1));
        vecs.push_back(mk("remu_zero",  2'b10, 7'b0000001, 3'b111, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 1'b0, 1'b0, 1));
        vecs.push_back(mk("div_ovf",    2'b10, 7'b0000001, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b0, 1));
        vecs.push_back(mk("rem_ovf",    2'b10, 7'b0000001, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0, 1));
        vecs.push_back(mk("mulhu",      2'b10, 7'b0000001, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0, 33));
        vecs.push_back(mk("mul_neg",    2'b10, 7'b0000001, 3'b000, 32'h0000_0003, 32'hFFFF_FFFE, 32'hFFFF_FFFA, 1'b0, 1'b0, 33));
        vecs.push_back(mk("mulh_neg",   2'b10, 7'b0000001, 3'b001, 32'h0000_0003, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0, 1'b0, 33));
        vecs.push_back(mk("mulhsu",     2'b10, 7'b0000001, 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 33));
        vecs.push_back(mk("rem_neg",    2'b10, 7'b0000001, 3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0, 1'b0, 33));
        vecs.push_back(mk("divu",       2'b10, 7'b0000001, 3'b101, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 1'b0, 1'b0, 33));
        vecs.push_back(mk("remu",       2'b10, 7'b0000001, 3'b111, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 1'b0, 1'b0, 33));
`else
        vecs.push_back(mk("m_illegal",  2'b10, 7'b0000001, 3'b000, 32'h0000_0003, 32'h0000_0004, 32'h0000_0000, 1'b0, 1'b1, 1));
        vecs.push_back(mk("div_illegal",2'b10, 7'b0000001, 3'b100, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0000, 1'b0, 1'b1, 1));
`endif

        // ---------------- reset state ----------------
        @(negedge clk);
        @(negedge clk);
        check("rst.in_ready",  {31'b0, bus_if.in_ready},     32'd0);
        check("rst.out_valid", {31'b0, bus_if.out_valid},    32'd0);
        check("rst.result",    bus_if.result,                32'd0);
        check("rst.taken",     {31'b0, bus_if.branch_taken}, 32'd0);
        check("rst.illegal",   {31'b0, bus_if.illegal},      32'd0);
        reset = 1'b0;
        #1;
        check("rst.ready_after", {31'b0, bus_if.in_ready}, 32'd1);

        // ---------------- vector table ----------------
        foreach (vecs[i]) begin
            v = vecs[i];
            issue(v);
            wait_valid(lat);
            check({v.name, ".latency"}, lat,                             v.lat);
            check({v.name, ".result"},  bus_if.result,                   v.res);
            check({v.name, ".taken"},   {31'b0, bus_if.branch_taken},    {31'b0, v.taken});
            check({v.name, ".illegal"}, {31'b0, bus_if.illegal},         {31'b0, v.ill});
            consume();
        end

        // ---------------- backpressure ----------------
        issue(mk("bp_add", 2'b10, 7'b0000000, 3'b000, 32'h0000_0001, 32'h0000_0002, 32'h3, 1'b0, 1'b0, 1));
        wait_valid(lat);
        // A competing request must not be taken while the result is held
        bus_if.alu_op   = 2'b10;
        bus_if.funct7   = 7'b0000000;
        bus_if.funct3   = 3'b110;
        bus_if.src_a    = 32'hFFFF_0000;
        bus_if.src_b    = 32'h0000_FFFF;
        bus_if.in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            check("bp.out_valid", {31'b0, bus_if.out_valid}, 32'd1);
            check("bp.result",    bus_if.result,             32'd3);
            check("bp.in_ready",  {31'b0, bus_if.in_ready},  32'd0);
            @(negedge clk);
        end
        bus_if.in_valid = 1'b0;
        consume();
        check("bp.release_ready", {31'b0, bus_if.in_ready},  32'd1);
        check("bp.release_valid", {31'b0, bus_if.out_valid}, 32'd0);

        // ---------------- reset mid-operation ----------------
`ifdef ALU_MULDIV_EN
        issue(mk("rst_div", 2'b10, 7'b0000001, 3'b100, 32'h0000_0064, 32'h0000_0007, 32'h0, 1'b0, 1'b0, 33));
`else
        issue(mk("rst_add", 2'b10, 7'b0000000, 3'b000, 32'h0000_0064, 32'h0000_0007, 32'h0, 1'b0, 1'b0, 1));
`endif
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rstmid.out_valid", {31'b0, bus_if.out_valid}, 32'd0);
        check("rstmid.in_ready",  {31'b0, bus_if.in_ready},  32'd1);
        check("rstmid.result",    bus_if.result,             32'd0);
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus_if.out_valid === 1'b1) seen++;
        end
        check("rstmid.no_stale", seen, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
